// File: rtl/fifo_sample_reader_pkg.sv
// rtl/fifo_sample_reader_pkg.sv - shared playout FSM encoding and underflow counter helpers
//
// Shared with the UART/DDS blocks.
//   run_state_t  : playout FSM states IDLE / PREFILL / RUN
//   UFLOW_CNT_W  : width of the saturating underflow event counter
//   sat_inc()    : saturating increment for that counter
package fifo_sample_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } run_state_t;

   localparam int UFLOW_CNT_W = 16;

   function automatic logic [UFLOW_CNT_W-1:0] sat_inc(input logic [UFLOW_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_sample_reader_rate_divider.sv
// rtl/fifo_sample_reader_rate_divider.sv - sample-rate divider producing a tick every rate_div+1 cycles
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at 0 and suppress tick (used outside RUN)
//   rate_div   : period minus one; compared live, so a change applies at the next comparison
//   tick       : high in a cycle where the count has reached rate_div
module rate_divider
   import fifo_sample_reader_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [DIV_WIDTH-1:0] rate_div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt;

   // >= rather than == so that lowering rate_div below the current count
   // ticks right away instead of wrapping the whole counter range.
   assign tick = !clear && (cnt >= rate_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_sample_reader.sv
// rtl/fifo_sample_reader.sv - paced FIFO reader feeding held samples to the DDS datapath
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : run request; low returns to IDLE on the next edge
//   rate_div       : sample period minus one, in clk cycles
//   prefill        : FIFO level needed before (re)starting playout (0 treated as 1)
//   fifo_dout      : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   fifo_count     : FIFO occupancy
//   fifo_rd_en     : registered single-cycle pop
//   sample_out     : current sample, held between updates
//   sample_valid   : one-cycle pulse when sample_out updates
//   underflow      : one-cycle pulse when a sample tick finds the FIFO empty
//   underflow_cnt  : saturating count of underflow events
//   running        : high while in RUN
module fifo_sample_reader
   import fifo_sample_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [DIV_WIDTH-1:0]   rate_div,
   input  logic [ADDR_WIDTH:0]    prefill,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   input  logic                   fifo_empty,
   input  logic [ADDR_WIDTH:0]    fifo_count,
   output logic                   fifo_rd_en,
   output logic [DATA_WIDTH-1:0]  sample_out,
   output logic                   sample_valid,
   output logic                   underflow,
   output logic [UFLOW_CNT_W-1:0] underflow_cnt,
   output logic                   running
);

   run_state_t            state;
   logic                  cap_pending;
   logic                  tick;
   logic [ADDR_WIDTH:0]   prefill_eff;

   assign prefill_eff = (prefill == '0) ? (ADDR_WIDTH+1)'(1) : prefill;

   // Divider is held at 0 outside RUN, so it restarts from 0 on every RUN entry.
   rate_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_rate_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state != ST_RUN),
      .rate_div (rate_div),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         fifo_rd_en    <= 1'b0;
         cap_pending   <= 1'b0;
         sample_out    <= '0;
         sample_valid  <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
         running       <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         underflow  <= 1'b0;

         // Capture pipeline runs regardless of FSM state so a word already
         // popped is always delivered, even across enable drop or underflow.
         cap_pending  <= fifo_rd_en;
         sample_valid <= cap_pending;
         if (cap_pending) begin
            sample_out <= fifo_dout;
         end

         if (!enable) begin
            state   <= ST_IDLE;
            running <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state   <= ST_PREFILL;
                  running <= 1'b0;
               end
               ST_PREFILL: begin
                  if (fifo_count >= prefill_eff) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // A tick landing in the pop cycle is absorbed: fifo_empty
                  // does not yet reflect that pop, and reads must not be
                  // back to back.
                  if (tick && !fifo_rd_en) begin
                     if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                     end else begin
                        underflow     <= 1'b1;
                        underflow_cnt <= sat_inc(underflow_cnt);
                        state         <= ST_PREFILL;
                        running       <= 1'b0;
                     end
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb/tb_fifo_sample_reader.sv - self-checking bench for fifo_sample_reader
module tb_fifo_sample_reader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int VW = 16;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          enable   = 1'b0;
   logic [VW-1:0] rate_div = '0;
   logic [AW:0]   prefill  = '0;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic          fifo_rd_en;
   logic [DW-1:0] sample_out;
   logic          sample_valid;
   logic          underflow;
   logic [15:0]   underflow_cnt;
   logic          running;

   always #5 clk = ~clk;

   fifo_sample_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DIV_WIDTH  (VW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .rate_div      (rate_div),
      .prefill       (prefill),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_count    (fifo_count),
      .fifo_rd_en    (fifo_rd_en),
      .sample_out    (sample_out),
      .sample_valid  (sample_valid),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt),
      .running       (running)
   );

   // FIFO model: registered read data one cycle after a pop; "lie" mode
   // reports count=1 yet empty=1 to provoke back-to-back underflows.
   logic [DW-1:0] mem [0:1023];
   logic [9:0]    wp, rp;
   logic [AW:0]   fcount;
   logic          wr_en   = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          lie     = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         fcount    <= '0;
         fifo_dout <= '0;
      end else begin
         if (fifo_rd_en && fcount != 0) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 1'b1;
         end
         if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 1'b1;
         end
         case ({wr_en, (fifo_rd_en && fcount != 0)})
            2'b10:   fcount <= fcount + 1'b1;
            2'b01:   fcount <= fcount - 1'b1;
            default: ;
         endcase
      end
   end

   assign fifo_empty = lie ? 1'b1 : (fcount == 0);
   assign fifo_count = lie ? (AW+1)'(1) : fcount;

   // Scoreboard: popped words must appear on sample_out in push order.
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_sample = '0;
   logic [15:0]   exp_ucnt    = '0;
   logic          rd_d1 = 1'b0, rd_d2 = 1'b0, prev_empty = 1'b0;
   int            rd_times [$];
   int            sv_seen = 0;
   int            uf_seen = 0;
   int            n;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (fifo_rd_en) begin
         rd_times.push_back(cyc);
         chk("rd_not_back_to_back", rd_d1, 0);
         chk("rd_only_in_run", running, 1);
      end
      chk("valid_two_after_rd", sample_valid, rd_d2);
      if (sample_valid) begin
         sv_seen++;
         chk("sample_has_word", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            last_sample = exp_q.pop_front();
            chk("sample_value", sample_out, last_sample);
         end
      end else begin
         chk("sample_hold", sample_out, last_sample);
      end
      if (underflow) begin
         uf_seen++;
         if (exp_ucnt != 16'hFFFF) exp_ucnt++;
         chk("underflow_on_empty", prev_empty, 1);
         chk("underflow_not_running", running, 0);
      end
      chk("underflow_cnt", underflow_cnt, exp_ucnt);
      rd_d2      = rd_d1;
      rd_d1      = fifo_rd_en;
      prev_empty = fifo_empty;
   endtask

   task automatic push(input logic [DW-1:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      exp_q.push_back(w);
      step();
      wr_en = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"},      fifo_rd_en,    0);
      chk({tag, "_sample_out"}, sample_out,    0);
      chk({tag, "_valid"},      sample_valid,  0);
      chk({tag, "_underflow"},  underflow,     0);
      chk({tag, "_uflow_cnt"},  underflow_cnt, 0);
      chk({tag, "_running"},    running,       0);
   endtask

   // Called just after a negedge: drops rst_n mid-cycle and checks outputs at once.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 chk_zero(tag);
      enable = 1'b0;
      wr_en  = 1'b0;
      lie    = 1'b0;
      exp_q.delete();
      last_sample = '0;
      exp_ucnt    = '0;
      rd_d1       = 1'b0;
      rd_d2       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      prev_empty = fifo_empty;
   endtask

   task automatic wait_running(input string tag, input int limit);
      n = 0;
      while (!running && n < limit) begin
         step();
         n++;
      end
      chk(tag, running, 1);
   endtask

   task automatic wait_rd(input string tag, input int limit);
      n = 0;
      while (!fifo_rd_en && n < limit) begin
         step();
         n++;
      end
      chk(tag, fifo_rd_en, 1);
   endtask

   initial begin
      // Power-on reset state
      repeat (2) @(negedge clk);
      chk_zero("por");
      rst_n      = 1'b1;
      prev_empty = fifo_empty;

      // Basic playout: prefill=4, rate_div=3, four preloaded words
      prefill  = 4;
      rate_div = 3;
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      rd_times.delete();
      sv_seen = 0;
      uf_seen = 0;
      enable  = 1'b1;
      n = 0;
      while (!running && n < 5) begin
         step();
         n++;
      end
      chk("run_within_2", (running && n <= 2), 1);
      repeat (22) step();
      chk("rd_count_4", rd_times.size(), 4);
      for (int i = 1; i < rd_times.size(); i++)
         chk("rd_period_4", rd_times[i] - rd_times[i-1], 4);
      chk("samples_4", sv_seen, 4);
      chk("drain_one_underflow", uf_seen, 1);
      chk("drain_uflow_cnt_1", underflow_cnt, 1);
      chk("drain_hold_44", sample_out, 32'h44);
      chk("drain_not_running", running, 0);

      // Refill returns to RUN, then drains again
      for (int k = 0; k < 4; k++) push($urandom);
      wait_running("refill_rerun", 3);
      repeat (22) step();

      // rate_div=0: reads in alternate cycles only
      enable = 1'b0;
      step();
      rate_div = 0;
      prefill  = 8;
      for (int k = 0; k < 8; k++) push($urandom);
      rd_times.delete();
      sv_seen = 0;
      enable  = 1'b1;
      repeat (25) step();
      chk("fast_rd_count_8", rd_times.size(), 8);
      for (int i = 1; i < rd_times.size(); i++)
         chk("fast_rd_gap_2", rd_times[i] - rd_times[i-1], 2);
      chk("fast_samples_8", sv_seen, 8);

      // Enable dropped in the read cycle: capture still completes
      enable = 1'b0;
      step();
      rate_div = 2;
      prefill  = 1;
      push($urandom); push($urandom);
      enable = 1'b1;
      wait_rd("drop_rd_seen", 20);
      enable = 1'b0;
      rd_times.delete();
      sv_seen = 0;
      repeat (10) step();
      chk("drop_one_sample", sv_seen, 1);
      chk("drop_no_more_rd", rd_times.size(), 0);
      chk("drop_idle", running, 0);

      // Asynchronous reset mid-RUN with a capture in flight
      for (int k = 0; k < 3; k++) push($urandom);
      rate_div = 1;
      enable   = 1'b1;
      wait_rd("rst_rd_seen", 20);
      step();
      do_reset("midrun");

      // Saturation of the underflow counter
      force dut.underflow_cnt = 16'hFFFE;
      exp_ucnt = 16'hFFFE;
      step();
      release dut.underflow_cnt;
      step();
      lie      = 1'b1;
      prefill  = 1;
      rate_div = 0;
      uf_seen  = 0;
      enable   = 1'b1;
      repeat (12) step();
      chk("sat_several_underflows", uf_seen >= 3, 1);
      chk("sat_holds_ffff", underflow_cnt, 16'hFFFF);
      enable = 1'b0;
      step();
      lie = 1'b0;
      step();
      do_reset("pre_random");

      // Randomized playout rounds
      for (int r = 0; r < 10; r++) begin
         rate_div = VW'($urandom_range(0, 5));
         prefill  = (AW+1)'($urandom_range(0, 4));
         enable   = 1'b1;
         for (int k = 0; k < int'($urandom_range(1, 8)); k++) push($urandom);
         repeat ($urandom_range(5, 40)) step();
         if ($urandom_range(0, 2) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 4)) step();
         end
      end
      enable = 1'b0;
      repeat (10) step();
      chk("no_dropped_words", exp_q.size(), fcount);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
